// File: rtl/race_start_scheduler_pkg.sv
// race_pkg: shared state encoding, default parameters and helpers for the race start scheduler
`timescale 1ns/1ps
package race_pkg;
  localparam int DEF_N_LANES = 4;
  localparam int DEF_PHASE_CYCLES = 3;
  localparam int DEF_DARK_CYCLES = 1;
  localparam int DEF_RT_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, RED, DARK1, YELLOW, DARK2, GREEN, RESULT} race_state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rr_lane_arbiter.sv
// rr_lane_arbiter: picks the first requesting lane at or after ptr_i, wrapping around
`timescale 1ns/1ps
module rr_lane_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  int j;
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    valid_o = 1'b0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr_i) + i) % N;
      if (|(req_i & (N'(1) << j))) begin
        grant_o = N'(1) << j;
        idx_o = IW'(j);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/race_start_scheduler.sv
// race_start_scheduler: light-tree start sequencer with round-robin lane grant and reaction timing
`timescale 1ns/1ps
module race_start_scheduler import race_pkg::*; #(
  parameter int N_LANES = DEF_N_LANES,
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int DARK_CYCLES = DEF_DARK_CYCLES,
  parameter int RT_WIDTH = DEF_RT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LANES-1:0]  req,
  input  logic [N_LANES-1:0]  launch,
  output logic [N_LANES-1:0]  grant,
  output logic                red,
  output logic                yellow,
  output logic                green,
  output logic [RT_WIDTH-1:0] reaction_time,
  output logic                done,
  output logic                false_start,
  output logic                timeout,
  output logic                aborted
);
  localparam int IW = max_int($clog2(N_LANES), 1);
  localparam int CW = max_int(RT_WIDTH, $clog2(max_int(PHASE_CYCLES, DARK_CYCLES) + 1));
  localparam logic [CW-1:0] GREEN_LAST = CW'({RT_WIDTH{1'b1}}) - CW'(1);
  race_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, phase_len;
  logic [N_LANES-1:0] grant_q, grant_d, arb_grant;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, arb_idx;
  logic [RT_WIDTH-1:0] rt_q, rt_d;
  logic done_q, done_d, fs_q, fs_d, to_q, to_d, ab_q, ab_d;
  logic red_q, yellow_q, green_q;
  logic arb_valid, req_g, launch_g, phase_end;
  rr_lane_arbiter #(.N(N_LANES), .IW(IW)) u_arb (
    .req_i(req),
    .ptr_i(ptr_q),
    .grant_o(arb_grant),
    .idx_o(arb_idx),
    .valid_o(arb_valid)
  );
  assign req_g = |(req & grant_q);
  assign launch_g = |(launch & grant_q);
  assign phase_len = (state_q == RED || state_q == YELLOW) ? CW'(PHASE_CYCLES) : CW'(DARK_CYCLES);
  assign phase_end = cnt_q == phase_len - CW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    grant_d = grant_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    rt_d = rt_q;
    done_d = 1'b0;
    fs_d = 1'b0;
    to_d = 1'b0;
    ab_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = RED;
          grant_d = arb_grant;
          idx_d = arb_idx;
        end
      end
      RED, DARK1, YELLOW, DARK2: begin
        cnt_d = phase_end ? '0 : cnt_q + CW'(1);
        state_d = phase_end ? race_state_e'(state_q + 3'd1) : state_q;
        // abort outranks a false start seen in the same cycle
        if (!req_g || launch_g) begin
          state_d = RESULT;
          done_d = 1'b1;
          ab_d = !req_g;
          fs_d = req_g;
          rt_d = '0;
        end
      end
      GREEN: begin
        cnt_d = cnt_q + CW'(1);
        if (!req_g || launch_g || cnt_q == GREEN_LAST) begin
          state_d = RESULT;
          done_d = 1'b1;
          ab_d = !req_g;
          to_d = req_g && !launch_g;
          rt_d = !req_g ? '0 : launch_g ? RT_WIDTH'(cnt_q + CW'(1)) : '1;
        end
      end
      RESULT: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d = idx_q == IW'(N_LANES - 1) ? '0 : idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      grant_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      rt_q <= '0;
      done_q <= 1'b0;
      fs_q <= 1'b0;
      to_q <= 1'b0;
      ab_q <= 1'b0;
      red_q <= 1'b1;
      yellow_q <= 1'b0;
      green_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      rt_q <= rt_d;
      done_q <= done_d;
      fs_q <= fs_d;
      to_q <= to_d;
      ab_q <= ab_d;
      red_q <= state_d == IDLE || state_d == RED || state_d == RESULT;
      yellow_q <= state_d == YELLOW;
      green_q <= state_d == GREEN;
    end
  end
  assign grant = grant_q;
  assign red = red_q;
  assign yellow = yellow_q;
  assign green = green_q;
  assign reaction_time = rt_q;
  assign done = done_q;
  assign false_start = fs_q;
  assign timeout = to_q;
  assign aborted = ab_q;
endmodule

// File: tb/tb_race_start_scheduler.sv
// tb_race_start_scheduler: directed races checked against a scoreboard of expected results
`timescale 1ns/1ps
module tb_race_start_scheduler;
  typedef struct packed {
    logic [3:0] g;
    logic [7:0] rt;
    logic fs;
    logic to;
    logic ab;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] launch = '0;
  logic [3:0] grant;
  logic red, yellow, green, done, false_start, timeout, aborted;
  logic [7:0] reaction_time;
  int checks = 0;
  int errors = 0;
  logic saw_green = 1'b0;
  logic lamp_bad = 1'b0;
  exp_t sb[$];
  always #5 clk = ~clk;
  race_start_scheduler dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .launch(launch),
    .grant(grant),
    .red(red),
    .yellow(yellow),
    .green(green),
    .reaction_time(reaction_time),
    .done(done),
    .false_start(false_start),
    .timeout(timeout),
    .aborted(aborted)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    if (green) saw_green = 1'b1;
    if ($countones({red, yellow, green}) > 1) lamp_bad = 1'b1;
  endtask
  task automatic push(input logic [3:0] g, input logic [7:0] rt, input logic fs, input logic to, input logic ab);
    exp_t e;
    e.g = g;
    e.rt = rt;
    e.fs = fs;
    e.to = to;
    e.ab = ab;
    sb.push_back(e);
  endtask
  task automatic wait_green(output int n);
    n = 0;
    while (!green && n < 40) begin
      tick;
      n++;
    end
  endtask
  task automatic wait_grant;
    int n = 0;
    while (grant == 4'd0 && n < 40) begin
      tick;
      n++;
    end
  endtask
  task automatic finish_race(input string tag, input logic drop);
    int n = 0;
    exp_t e;
    while (!done && n < 400) begin
      tick;
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (drop) req = '0;
    launch = '0;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_grant"}, 32'(grant), 32'(e.g));
      chk({tag, "_rt"}, 32'(reaction_time), 32'(e.rt));
      chk({tag, "_flags"}, 32'({false_start, timeout, aborted}), 32'({e.fs, e.to, e.ab}));
      tick;
      chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
      chk({tag, "_grant_clr"}, 32'(grant), 32'd0);
      chk({tag, "_flags_clr"}, 32'({false_start, timeout, aborted}), 32'd0);
      chk({tag, "_rt_hold"}, 32'(reaction_time), 32'(e.rt));
    end
  endtask
  initial begin
    int n;
    logic [3:0] eg;
    tick;
    tick;
    chk("rst_lamps", 32'({red, yellow, green}), 32'b100);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_flags", 32'({done, false_start, timeout, aborted}), 32'd0);
    chk("rst_rt", 32'(reaction_time), 32'd0);
    rst = 1'b0;
    tick;
    // clean race, launch on 5th green cycle
    req = 4'b0001;
    tick;
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_red", 32'(red), 32'd1);
    wait_green(n);
    chk("t1_green_delay", 32'(n), 32'd8);
    chk("t1_grant_green", 32'(grant), 32'b0001);
    repeat (4) tick;
    launch = 4'b0001;
    push(4'b0001, 8'd5, 1'b0, 1'b0, 1'b0);
    finish_race("t1", 1'b1);
    // false start in 2nd yellow cycle
    saw_green = 1'b0;
    req = 4'b0001;
    tick;
    chk("t2_grant", 32'(grant), 32'b0001);
    repeat (4) tick;
    chk("t2_yellow", 32'(yellow), 32'd1);
    tick;
    launch = 4'b0001;
    push(4'b0001, 8'd0, 1'b1, 1'b0, 1'b0);
    tick;
    launch = '0;
    finish_race("t2", 1'b1);
    chk("t2_no_green", 32'(saw_green), 32'd0);
    // round robin over all four lanes
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      eg = 4'(1 << (i % 4));
      wait_grant;
      chk("t3_rr_grant", 32'(grant), 32'(eg));
      wait_green(n);
      launch = grant;
      push(eg, 8'd1, 1'b0, 1'b0, 1'b0);
      finish_race("t3", 1'b0);
    end
    req = '0;
    // no launch at all: saturating timeout
    req = 4'b0001;
    tick;
    chk("t4_grant", 32'(grant), 32'b0001);
    wait_green(n);
    push(4'b0001, 8'd255, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!done && n < 300) begin
      tick;
      n++;
    end
    chk("t4_green_cycles", 32'(n), 32'd255);
    finish_race("t4", 1'b1);
    // reset in the middle of yellow
    req = 4'b0010;
    tick;
    chk("t5_grant", 32'(grant), 32'b0010);
    repeat (4) tick;
    chk("t5_yellow", 32'(yellow), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_rst_lamps", 32'({red, yellow, green}), 32'b100);
    chk("t5_rst_grant_done", 32'({grant, done}), 32'd0);
    req = 4'b0011;
    tick;
    chk("t5_restart_lane0", 32'(grant), 32'b0001);
    // other lane launches early, then granted lane drops its request
    saw_green = 1'b0;
    launch = 4'b0010;
    tick;
    tick;
    launch = '0;
    repeat (5) tick;
    chk("t6_dark2_off", 32'({red, yellow, green}), 32'd0);
    chk("t6_still_granted", 32'(grant), 32'b0001);
    req = 4'b0010;
    push(4'b0001, 8'd0, 1'b0, 1'b0, 1'b1);
    finish_race("t6", 1'b1);
    chk("t6_no_green", 32'(saw_green), 32'd0);
    chk("lamps_onehot", 32'(lamp_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
